// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-lite memory initiator and its watchdog.
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } axil_state_e;

    localparam logic [2:0] AXI_PROT_DATA = 3'b000;
    localparam logic [2:0] AXI_PROT_INSN = 3'b100;
    localparam logic [3:0] STRB_READ     = 4'b0000;

    // States in which the initiator is waiting on the slave.
    function automatic logic is_waiting(input axil_state_e state);
        return (state != ST_IDLE) && (state != ST_DONE);
    endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Saturating cycle counter with a sticky expiry flag; a limit of zero disables the flag.
module axil_watchdog #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;
    logic             r_expired;
    logic             w_armed;
    logic [CNT_W-1:0] w_ceiling;
    logic [CNT_W-1:0] w_count_inc;

    assign w_armed     = (i_limit != '0);
    assign w_ceiling   = w_armed ? i_limit : CNT_MAX;
    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else if (i_clear) begin
            // The flag is sticky: only reset clears it, never a new transaction.
            r_count <= '0;
        end else if (i_enable && (r_count != w_ceiling)) begin
            r_count <= w_count_inc;
            if (w_armed && (w_count_inc == i_limit)) begin
                r_expired <= 1'b1;
            end
        end
    end

    assign o_expired = r_expired;

endmodule

// File: rtl/axil_mem_master.sv
// Native valid/ready memory request to AXI4-lite initiator, one transaction in flight,
// with a watchdog that flags a slave that stalls too long.
module axil_mem_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic              mem_axi_awvalid,
    input  logic              mem_axi_awready,
    output logic [ADDR_W-1:0] mem_axi_awaddr,
    output logic [2:0]        mem_axi_awprot,
    output logic              mem_axi_wvalid,
    input  logic              mem_axi_wready,
    output logic [31:0]       mem_axi_wdata,
    output logic [3:0]        mem_axi_wstrb,
    input  logic              mem_axi_bvalid,
    output logic              mem_axi_bready,
    output logic              mem_axi_arvalid,
    input  logic              mem_axi_arready,
    output logic [ADDR_W-1:0] mem_axi_araddr,
    output logic [2:0]        mem_axi_arprot,
    input  logic              mem_axi_rvalid,
    output logic              mem_axi_rready,
    input  logic [31:0]       mem_axi_rdata,
    output logic              err_timeout
);

    import axil_pkg::*;

    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);

    axil_state_e       r_state;
    logic              r_mem_ready;
    logic [31:0]       r_mem_rdata;
    logic              r_awvalid;
    logic [ADDR_W-1:0] r_awaddr;
    logic              r_wvalid;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_bready;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic [2:0]        r_arprot;
    logic              r_rready;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_wd_clear;
    logic w_wd_enable;
    logic w_wd_expired;

    // AW and W complete independently; a channel is done once its handshake has been seen.
    assign w_aw_hs   = r_awvalid & mem_axi_awready;
    assign w_w_hs    = r_wvalid & mem_axi_wready;
    assign w_aw_done = r_aw_done | w_aw_hs;
    assign w_w_done  = r_w_done | w_w_hs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_awvalid   <= 1'b0;
            r_awaddr    <= '0;
            r_wvalid    <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arprot    <= AXI_PROT_DATA;
            r_rready    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere in this block, so every branch
            // reads the pre-edge register values regardless of statement order.
            r_mem_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mem_valid) begin
                        if (mem_wstrb == STRB_READ) begin
                            r_araddr  <= mem_addr;
                            r_arprot  <= mem_instr ? AXI_PROT_INSN : AXI_PROT_DATA;
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end else begin
                            r_awaddr  <= mem_addr;
                            r_wdata   <= mem_wdata;
                            r_wstrb   <= mem_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_WR_REQ;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (r_arvalid && mem_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (mem_axi_rvalid && r_rready) begin
                        r_mem_rdata <= mem_axi_rdata;
                        r_rready    <= 1'b0;
                        r_mem_ready <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_done;
                    r_w_done  <= w_w_done;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (mem_axi_bvalid && r_bready) begin
                        r_bready    <= 1'b0;
                        r_mem_ready <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // mem_valid is ignored here: the core still holds it during the ready pulse.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_wd_clear  = (r_state == ST_IDLE);
    assign w_wd_enable = is_waiting(r_state);

    axil_watchdog #(
        .CNT_W(32)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (resetn),
        .i_clear  (w_wd_clear),
        .i_enable (w_wd_enable),
        .i_limit  (WD_LIMIT),
        .o_expired(w_wd_expired)
    );

    assign mem_ready       = r_mem_ready;
    assign mem_rdata       = r_mem_rdata;
    assign mem_axi_awvalid = r_awvalid;
    assign mem_axi_awaddr  = r_awaddr;
    assign mem_axi_awprot  = AXI_PROT_DATA;
    assign mem_axi_wvalid  = r_wvalid;
    assign mem_axi_wdata   = r_wdata;
    assign mem_axi_wstrb   = r_wstrb;
    assign mem_axi_bready  = r_bready;
    assign mem_axi_arvalid = r_arvalid;
    assign mem_axi_araddr  = r_araddr;
    assign mem_axi_arprot  = r_arprot;
    assign mem_axi_rready  = r_rready;
    assign err_timeout     = w_wd_expired;

endmodule

// File: tb/tb_axil_mem_master.sv
// Randomized bench: a cycle-level AXI4-lite slave with its own memory, checked against
// a request-level reference memory and latency/protocol rules.
module tb_axil_mem_master;

    logic        clk;
    logic        resetn;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_axi_awvalid;
    logic        mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid;
    logic        mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid;
    logic        mem_axi_bready;
    logic        mem_axi_arvalid;
    logic        mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid;
    logic        mem_axi_rready;
    logic [31:0] mem_axi_rdata;
    logic        err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] slv_mem [256];

    axil_mem_master #(
        .TIMEOUT_CYCLES(8),
        .ADDR_W        (32)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem_valid      (mem_valid),
        .mem_instr      (mem_instr),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_rdata      (mem_rdata),
        .mem_axi_awvalid(mem_axi_awvalid),
        .mem_axi_awready(mem_axi_awready),
        .mem_axi_awaddr (mem_axi_awaddr),
        .mem_axi_awprot (mem_axi_awprot),
        .mem_axi_wvalid (mem_axi_wvalid),
        .mem_axi_wready (mem_axi_wready),
        .mem_axi_wdata  (mem_axi_wdata),
        .mem_axi_wstrb  (mem_axi_wstrb),
        .mem_axi_bvalid (mem_axi_bvalid),
        .mem_axi_bready (mem_axi_bready),
        .mem_axi_arvalid(mem_axi_arvalid),
        .mem_axi_arready(mem_axi_arready),
        .mem_axi_araddr (mem_axi_araddr),
        .mem_axi_arprot (mem_axi_arprot),
        .mem_axi_rvalid (mem_axi_rvalid),
        .mem_axi_rready (mem_axi_rready),
        .mem_axi_rdata  (mem_axi_rdata),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    task automatic slave_idle();
        mem_axi_awready = 1'b0;
        mem_axi_wready  = 1'b0;
        mem_axi_bvalid  = 1'b0;
        mem_axi_arready = 1'b0;
        mem_axi_rvalid  = 1'b0;
        mem_axi_rdata   = '0;
    endtask

    // One native request against a slave that inserts the given per-channel delays.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic instr,
                           input int ar_dly, input int r_dly, input int aw_dly,
                           input int w_dly, input int b_dly, input bit wd_probe);
        int ready_iter, n_ready, n_ar, n_r, n_aw, n_w, n_b, proto_err, exp_lat;
        int ar_seen, r_seen, aw_seen, w_seen, b_seen;
        logic [31:0] hs_araddr, hs_awaddr, hs_wdata, old_rdata, rdata_at_ready;
        logic [2:0]  hs_arprot;
        logic [3:0]  hs_wstrb, p_wstrb;
        logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_rr, p_rv, p_br, p_bv;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        bit          is_read;

        ready_iter = -1; n_ready = 0; n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
        proto_err = 0; ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
        hs_araddr = '0; hs_awaddr = '0; hs_wdata = '0; hs_arprot = '0; hs_wstrb = '0;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        p_rr = 0; p_rv = 0; p_br = 0; p_bv = 0;
        p_araddr = '0; p_awaddr = '0; p_wdata = '0; p_wstrb = '0;
        rdata_at_ready = '0;
        is_read = (strb == 4'h0);
        exp_lat = is_read ? ar_dly + r_dly + 2
                          : ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 2;
        old_rdata = mem_rdata;

        mem_addr  = addr;
        mem_wdata = data;
        mem_wstrb = strb;
        mem_instr = instr;
        mem_valid = 1'b1;

        for (int iter = 0; iter < 80; iter++) begin
            @(posedge clk);
            #1;
            if (ready_iter >= 0 && iter == ready_iter + 1) mem_valid = 1'b0;

            if (p_arv && !p_arr && (!mem_axi_arvalid || mem_axi_araddr !== p_araddr)) proto_err++;
            if (p_arv && p_arr && mem_axi_arvalid) proto_err++;
            if (p_awv && !p_awr && (!mem_axi_awvalid || mem_axi_awaddr !== p_awaddr)) proto_err++;
            if (p_awv && p_awr && mem_axi_awvalid) proto_err++;
            if (p_wv && !p_wr && (!mem_axi_wvalid || mem_axi_wdata !== p_wdata
                                  || mem_axi_wstrb !== p_wstrb)) proto_err++;
            if (p_wv && p_wr && mem_axi_wvalid) proto_err++;
            if (p_rr && !p_rv && !mem_axi_rready) proto_err++;
            if (p_rr && p_rv && mem_axi_rready) proto_err++;
            if (p_br && !p_bv && !mem_axi_bready) proto_err++;
            if (p_br && p_bv && mem_axi_bready) proto_err++;
            if (mem_axi_bready && (n_aw == 0 || n_w == 0)) proto_err++;
            if (mem_axi_rready && n_ar == 0) proto_err++;

            if (mem_ready) begin
                n_ready++;
                if (ready_iter < 0) begin
                    ready_iter     = iter;
                    rdata_at_ready = mem_rdata;
                end
            end

            if (wd_probe && iter == 7) check({tag, ".err_before_limit"}, err_timeout, 1'b0);
            if (wd_probe && iter == 8) begin
                check({tag, ".err_at_limit"}, err_timeout, 1'b1);
                check({tag, ".arvalid_held"}, mem_axi_arvalid, 1'b1);
            end

            if (mem_axi_arvalid) begin
                mem_axi_arready = (ar_seen >= ar_dly);
                ar_seen++;
                if (mem_axi_arready) begin
                    n_ar++;
                    hs_araddr = mem_axi_araddr;
                    hs_arprot = mem_axi_arprot;
                end
            end else begin
                mem_axi_arready = ($urandom_range(0, 3) == 0);
            end

            if (mem_axi_rready) begin
                mem_axi_rvalid = (r_seen >= r_dly);
                r_seen++;
                mem_axi_rdata = slv_mem[hs_araddr[9:2]];
                if (mem_axi_rvalid) n_r++;
            end else begin
                mem_axi_rvalid = 1'b0;
                mem_axi_rdata  = $urandom;
            end

            if (mem_axi_awvalid) begin
                mem_axi_awready = (aw_seen >= aw_dly);
                aw_seen++;
                if (mem_axi_awready) begin
                    n_aw++;
                    hs_awaddr = mem_axi_awaddr;
                end
            end else begin
                mem_axi_awready = ($urandom_range(0, 3) == 0);
            end

            if (mem_axi_wvalid) begin
                mem_axi_wready = (w_seen >= w_dly);
                w_seen++;
                if (mem_axi_wready) begin
                    n_w++;
                    hs_wdata = mem_axi_wdata;
                    hs_wstrb = mem_axi_wstrb;
                end
            end else begin
                mem_axi_wready = ($urandom_range(0, 3) == 0);
            end

            if (mem_axi_bready) begin
                mem_axi_bvalid = (b_seen >= b_dly);
                b_seen++;
                if (mem_axi_bvalid) begin
                    n_b++;
                    slv_mem[hs_awaddr[9:2]] = merge(slv_mem[hs_awaddr[9:2]], hs_wdata, hs_wstrb);
                end
            end else begin
                mem_axi_bvalid = 1'b0;
            end

            p_arv = mem_axi_arvalid; p_arr = mem_axi_arready; p_araddr = mem_axi_araddr;
            p_awv = mem_axi_awvalid; p_awr = mem_axi_awready; p_awaddr = mem_axi_awaddr;
            p_wv  = mem_axi_wvalid;  p_wr  = mem_axi_wready;
            p_wdata = mem_axi_wdata; p_wstrb = mem_axi_wstrb;
            p_rr  = mem_axi_rready;  p_rv  = mem_axi_rvalid;
            p_br  = mem_axi_bready;  p_bv  = mem_axi_bvalid;

            if (ready_iter >= 0 && iter >= ready_iter + 3) break;
        end
        slave_idle();
        mem_valid = 1'b0;

        check({tag, ".ready_pulses"}, n_ready, 1);
        check({tag, ".latency"}, ready_iter, exp_lat);
        check({tag, ".protocol_errors"}, proto_err, 0);
        if (is_read) begin
            check({tag, ".ar_count"}, n_ar, 1);
            check({tag, ".r_count"}, n_r, 1);
            check({tag, ".write_activity"}, n_aw + n_w + n_b, 0);
            check({tag, ".araddr"}, hs_araddr, addr);
            check({tag, ".arprot"}, hs_arprot, {instr, 2'b00});
            check({tag, ".rdata"}, rdata_at_ready, ref_mem[addr[9:2]]);
            check({tag, ".rdata_held"}, mem_rdata, ref_mem[addr[9:2]]);
        end else begin
            check({tag, ".aw_w_b_counts"}, {n_aw[7:0], n_w[7:0], n_b[7:0]}, 24'h010101);
            check({tag, ".read_activity"}, n_ar, 0);
            check({tag, ".awaddr"}, hs_awaddr, addr);
            check({tag, ".wdata"}, hs_wdata, data);
            check({tag, ".wstrb"}, hs_wstrb, strb);
            check({tag, ".rdata_untouched"}, mem_rdata, old_rdata);
            ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], data, strb);
        end
    endtask

    initial begin
        int n_pulse;
        logic [31:0] r_addr;
        bit is_wr;

        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        slave_idle();
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        ref_mem[8'h40] = 32'h1234_5678;
        slv_mem[8'h40] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1;
        check("reset.valids", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready,
                               mem_axi_arvalid, mem_axi_rready, mem_ready}, 6'b0);
        check("reset.rdata", mem_rdata, 32'h0);
        check("reset.err", err_timeout, 1'b0);
        check("reset.payload", {mem_axi_awaddr, mem_axi_araddr}, 64'h0);
        check("reset.prot", {mem_axi_awprot, mem_axi_arprot, mem_axi_wstrb}, 10'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_txn("rd_zero_wait", 32'h100, 32'h0, 4'h0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
        run_txn("fetch", 32'h0, 32'h0, 4'h0, 1'b1, 0, 0, 0, 0, 0, 1'b0);
        run_txn("wr_skewed", 32'h200, 32'hA5A5_A5A5, 4'b0011, 1'b0, 0, 0, 3, 1, 0, 1'b0);
        run_txn("rd_after_wr", 32'h200, 32'h0, 4'h0, 1'b0, 1, 1, 0, 0, 0, 1'b0);
        run_txn("rd_backpressure", 32'h3FC, 32'h0, 4'h0, 1'b0, 5, 0, 0, 0, 0, 1'b0);

        // Delays stay within the watchdog limit so err_timeout must remain clear.
        for (int t = 0; t < 40; t++) begin
            r_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            is_wr  = ($urandom_range(0, 1) == 1);
            if (is_wr)
                run_txn("rand_wr", r_addr, $urandom, 4'($urandom_range(1, 15)), 1'b0,
                        0, 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), 1'b0);
            else
                run_txn("rand_rd", r_addr, 32'h0, 4'h0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 4), $urandom_range(0, 1), 0, 0, 0, 1'b0);
        end
        check("err_quiet", err_timeout, 1'b0);

        run_txn("watchdog", 32'h40, 32'h0, 4'h0, 1'b0, 11, 0, 0, 0, 0, 1'b1);
        check("watchdog.sticky", err_timeout, 1'b1);

        // Reset mid-write: the slave never accepts, then reset pulls everything down at once.
        mem_addr  = 32'h80;
        mem_wdata = 32'hDEAD_BEEF;
        mem_wstrb = 4'hF;
        mem_instr = 1'b0;
        mem_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid.valid_before", {mem_axi_awvalid, mem_axi_wvalid}, 2'b11);
        resetn = 1'b0;
        #1;
        check("rst_mid.valids", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready,
                                 mem_axi_arvalid, mem_axi_rready}, 5'b0);
        check("rst_mid.err", err_timeout, 1'b0);
        mem_valid = 1'b0;
        n_pulse = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (mem_ready) n_pulse++;
        end
        resetn = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (mem_ready) n_pulse++;
        end
        check("rst_mid.no_ready", n_pulse, 0);
        check("rst_mid.rdata_cleared", mem_rdata, 32'h0);
        run_txn("rd_after_reset", 32'h80, 32'h0, 4'h0, 1'b0, 0, 0, 0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
